// File: rtl/seg_scan_driver_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared types and constants for the 7-segment scan driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Matches the active-high blanking input of the downstream decoder.
    localparam logic BLANK = 1'b1;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage : seg_pkg

`default_nettype wire

// File: rtl/seg_scan_driver_lzb.sv
// ============================================================================
// Module  : seg_lzb
// Brief   : Per-digit blank vector from display mask and leading-zero rule.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_lzb
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int LZB    = 1
) (
    input  logic [4*DIGITS-1:0] nibbles,
    input  logic [DIGITS-1:0]   mask,
    output logic [DIGITS-1:0]   blank
);

    logic [DIGITS-1:0] zero;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            assign zero[i] = (nibbles[4*i +: 4] == 4'd0);

            // Digit 0 is never suppressed so an all-zero value still shows "0".
            if (i == 0) begin : g_d0
                assign blank[i] = mask[i];
            end else begin : g_dn
                assign blank[i] = mask[i] | ((LZB != 0) && (&zero[DIGITS-1:i]));
            end
        end
    endgenerate

endmodule : seg_lzb

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module  : seg_scan_driver
// Brief   : Multiplexed common-anode 7-seg scan with frame-synchronous update.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 500,
    parameter int LZB    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   blank_mask,
    output logic [3:0]          data,
    output logic                ctrl,
    output logic [DIGITS-1:0]   an,
    output logic                pending
);

    localparam int CW = cnt_width(DIV, DEAD);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]     DEAD_LAST  = CW'(DEAD - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [DIGITS-1:0]    smask_q, smask_d;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic [DIGITS-1:0]    dmask_q, dmask_d;
    logic                 pending_q, pending_d;
    logic [3:0]           data_q, data_d;
    logic                 ctrl_q, ctrl_d;
    logic [DIGITS-1:0]    an_q, an_d;

    logic                 dead_done;
    logic                 show_done;
    logic                 commit;
    logic [DIGITS-1:0]    blank_vec;

    // Blanking is evaluated on the next display contents so the first SHOW
    // cycle after a commit already reflects the new value.
    seg_lzb #(
        .DIGITS (DIGITS),
        .LZB    (LZB)
    ) u_lzb (
        .nibbles (disp_d),
        .mask    (dmask_d),
        .blank   (blank_vec)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        smask_d   = smask_q;
        disp_d    = disp_q;
        dmask_d   = dmask_q;
        pending_d = pending_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        an_d      = an_q;

        dead_done = (state_q == ST_DEAD) && (cnt_q == DEAD_LAST);
        show_done = (state_q == ST_SHOW) && (cnt_q == DIV_LAST);
        commit    = dead_done && (idx_q == '0) && pending_q;

        if (load) begin
            shadow_d  = value;
            smask_d   = blank_mask;
            pending_d = 1'b1;
        end

        // A load on the commit edge keeps pending set for the next frame.
        if (commit) begin
            disp_d  = shadow_q;
            dmask_d = smask_q;
            if (!load) begin
                pending_d = 1'b0;
            end
        end

        if (dead_done) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            an_d    = AN_ALL_OFF & ~(DIGITS'(1) << idx_q);
            data_d  = disp_d[{idx_q, 2'b00} +: 4];
            ctrl_d  = blank_vec[idx_q];
        end else if (show_done) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            an_d    = AN_ALL_OFF;
            ctrl_d  = BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_DEAD;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            smask_q   <= '0;
            disp_q    <= '0;
            dmask_q   <= '0;
            pending_q <= 1'b0;
            data_q    <= 4'd0;
            ctrl_q    <= BLANK;
            an_q      <= AN_ALL_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            smask_q   <= smask_d;
            disp_q    <= disp_d;
            dmask_q   <= dmask_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            an_q      <= an_d;
        end
    end

    assign data    = data_q;
    assign ctrl    = ctrl_q;
    assign an      = an_q;
    assign pending = pending_q;

endmodule : seg_scan_driver

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module  : tb_seg_scan_driver
// Brief   : Directed self-checking bench for seg_scan_driver (4 digits).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int DEAD   = 1;
    localparam int LZB    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  data;
    logic        ctrl;
    logic [3:0]  an;
    logic        pending;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  mask;
        logic [15:0] exp_data;
        logic [3:0]  exp_ctrl;
    } vec_t;

    vec_t vecs [5];

    seg_scan_driver #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD),
        .LZB    (LZB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .data       (data),
        .ctrl       (ctrl),
        .an         (an),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int target);
        while (k < target) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an,
                           input logic [3:0] e_data, input logic e_ctrl);
        chk({tag, ".an"},   {28'd0, an},   {28'd0, e_an});
        chk({tag, ".data"}, {28'd0, data}, {28'd0, e_data});
        chk({tag, ".ctrl"}, {31'd0, ctrl}, {31'd0, e_ctrl});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        load       = 1'b1;
        value      = v;
        blank_mask = m;
        tick();
        load       = 1'b0;
    endtask

    initial begin
        int b;
        vecs[0] = '{value: 16'h1234, mask: 4'b0000, exp_data: 16'h1234, exp_ctrl: 4'b0000};
        vecs[1] = '{value: 16'h0042, mask: 4'b0001, exp_data: 16'h0042, exp_ctrl: 4'b1101};
        vecs[2] = '{value: 16'h0000, mask: 4'b0000, exp_data: 16'h0000, exp_ctrl: 4'b1110};
        vecs[3] = '{value: 16'hF0A0, mask: 4'b0100, exp_data: 16'hF0A0, exp_ctrl: 4'b0100};
        vecs[4] = '{value: 16'h0100, mask: 4'b1000, exp_data: 16'h0100, exp_ctrl: 4'b1000};

        // Inputs wiggle without load; display must stay at zero.
        rst        = 1'b1;
        load       = 1'b0;
        value      = 16'hFFFF;
        blank_mask = 4'b1111;
        tick();
        chk_out("reset", 4'b1111, 4'h0, 1'b1);
        chk("reset.pending", {31'd0, pending}, 32'd0);
        tick();
        rst = 1'b0;
        k   = 0;

        chk_out("rel.dead", 4'b1111, 4'h0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            goto(c);
            chk_out("rel.d0", 4'b1110, 4'h0, 1'b0);
        end
        goto(5);  chk_out("rel.gap", 4'b1111, 4'h0, 1'b1);
        goto(6);  chk_out("rel.d1", 4'b1101, 4'h0, 1'b1);
        goto(11); chk_out("rel.d2", 4'b1011, 4'h0, 1'b1);
        goto(16); chk_out("rel.d3", 4'b0111, 4'h0, 1'b1);

        // Table: load mid-frame, commit at the boundary, check the whole frame.
        for (int i = 0; i < 5; i++) begin
            b = 41 + 40 * i;
            goto(b - 10);
            do_load(vecs[i].value, vecs[i].mask);
            chk("tbl.pend_set", {31'd0, pending}, 32'd1);
            goto(b - 1);
            chk("tbl.pend_hold", {31'd0, pending}, 32'd1);
            for (int d = 0; d < 4; d++) begin
                for (int p = 0; p < 4; p++) begin
                    goto(b + 5 * d + p);
                    chk_out("tbl.show", ~(4'b0001 << d), vecs[i].exp_data[4*d +: 4],
                            vecs[i].exp_ctrl[d]);
                    chk("tbl.pend_clr", {31'd0, pending}, 32'd0);
                end
                goto(b + 5 * d + 4);
                chk_out("tbl.dead", 4'b1111, vecs[i].exp_data[4*d +: 4], 1'b1);
            end
        end

        // Mid-frame load must not tear the frame being shown.
        goto(225);
        do_load(16'h1234, 4'b0000);
        goto(246);
        chk_out("mid.pre_d1", 4'b1101, 4'h3, 1'b0);
        do_load(16'h5678, 4'b0000);
        chk_out("mid.d1", 4'b1101, 4'h3, 1'b0);
        chk("mid.pend", {31'd0, pending}, 32'd1);
        goto(251); chk_out("mid.d2", 4'b1011, 4'h2, 1'b0);
        goto(256); chk_out("mid.d3", 4'b0111, 4'h1, 1'b0);
        goto(260); chk("mid.pend_dead", {31'd0, pending}, 32'd1);
        goto(261); chk_out("mid.new_d0", 4'b1110, 4'h8, 1'b0);
        chk("mid.pend_clr", {31'd0, pending}, 32'd0);
        goto(266); chk_out("mid.new_d1", 4'b1101, 4'h7, 1'b0);
        goto(271); chk_out("mid.new_d2", 4'b1011, 4'h6, 1'b0);
        goto(276); chk_out("mid.new_d3", 4'b0111, 4'h5, 1'b0);

        // Load landing on the commit edge: old shadow shows, new one waits.
        goto(285);
        do_load(16'h1111, 4'b0000);
        goto(300);
        do_load(16'h9999, 4'b0000);
        chk_out("sim.d0", 4'b1110, 4'h1, 1'b0);
        chk("sim.pend", {31'd0, pending}, 32'd1);
        goto(306); chk_out("sim.d1", 4'b1101, 4'h1, 1'b0);
        goto(311); chk_out("sim.d2", 4'b1011, 4'h1, 1'b0);
        goto(316); chk_out("sim.d3", 4'b0111, 4'h1, 1'b0);
        chk("sim.pend_hold", {31'd0, pending}, 32'd1);
        goto(321); chk_out("sim.next_d0", 4'b1110, 4'h9, 1'b0);
        chk("sim.pend_clr", {31'd0, pending}, 32'd0);
        goto(326); chk_out("sim.next_d1", 4'b1101, 4'h9, 1'b0);
        goto(331); chk_out("sim.next_d2", 4'b1011, 4'h9, 1'b0);

        // Asynchronous reset during digit 2's SHOW slot.
        goto(332);
        rst = 1'b1;
        #1;
        chk_out("arst.imm", 4'b1111, 4'h0, 1'b1);
        chk("arst.pend", {31'd0, pending}, 32'd0);
        tick();
        chk_out("arst.hold", 4'b1111, 4'h0, 1'b1);
        rst = 1'b0;
        k   = 0;
        chk_out("arst.dead", 4'b1111, 4'h0, 1'b1);
        goto(1); chk_out("arst.d0", 4'b1110, 4'h0, 1'b0);
        goto(6); chk_out("arst.d1", 4'b1101, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg_scan_driver

`default_nettype wire
